// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster geometry and shared coordinate type for the VGA timing path.
package vga_timing_pkg;

   localparam int unsigned H_ACTIVE_D = 640;
   localparam int unsigned H_FP_D     = 16;
   localparam int unsigned H_SYNC_D   = 96;
   localparam int unsigned H_BP_D     = 48;
   localparam int unsigned V_ACTIVE_D = 480;
   localparam int unsigned V_FP_D     = 10;
   localparam int unsigned V_SYNC_D   = 2;
   localparam int unsigned V_BP_D     = 33;
   localparam int unsigned CW_D       = 10;

   // Total period of one axis: active + front porch + sync + back porch.
   function automatic int unsigned span_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   localparam int unsigned H_TOTAL_D = span_total(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
   localparam int unsigned V_TOTAL_D = span_total(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);

   typedef logic [CW_D-1:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// Modulo-MOD up-counter that resets to its terminal value so the first increment lands on zero.
module mod_counter #(
   parameter int unsigned MOD = 800,
   parameter int unsigned W   = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         wrap
);

   localparam logic [W-1:0] TERM = W'(MOD - 1);

   // Terminal-count flag; used by the parent as the carry into the next axis.
   assign wrap = (count == TERM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= TERM;
      end else if (inc) begin
         count <= wrap ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: col/row scan with registered sync, active and line/frame strobes
// aligned to the counters by decoding the next-state counts.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_D,
   parameter int unsigned H_FP     = H_FP_D,
   parameter int unsigned H_SYNC   = H_SYNC_D,
   parameter int unsigned H_BP     = H_BP_D,
   parameter int unsigned V_ACTIVE = V_ACTIVE_D,
   parameter int unsigned V_FP     = V_FP_D,
   parameter int unsigned V_SYNC   = V_SYNC_D,
   parameter int unsigned V_BP     = V_BP_D,
   parameter logic        H_POL    = 1'b0,
   parameter logic        V_POL    = 1'b0,
   parameter int unsigned CW       = CW_D
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ce,
   output logic [CW-1:0] col,
   output logic [CW-1:0] row,
   output logic          HSync,
   output logic          VSync,
   output logic          active,
   output logic          line_start,
   output logic          frame_start
);

   localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_START  = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_START  = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);

   if ((64'(H_TOTAL) > (64'(1) << CW)) || (64'(V_TOTAL) > (64'(1) << CW))) begin : g_cw_check
      $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
   end

   logic          w_h_wrap;
   logic          w_v_wrap;
   logic          w_v_inc;
   logic [CW-1:0] w_col_nxt;
   logic [CW-1:0] w_row_nxt;

   assign w_v_inc = ce & w_h_wrap;

   mod_counter #(
      .MOD (H_TOTAL),
      .W   (CW)
   ) u_h_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ce),
      .count (col),
      .wrap  (w_h_wrap)
   );

   mod_counter #(
      .MOD (V_TOTAL),
      .W   (CW)
   ) u_v_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_v_inc),
      .count (row),
      .wrap  (w_v_wrap)
   );

   // Counter values after the next enabled pixel; decoding these keeps strobes coincident with col/row.
   assign w_col_nxt = w_h_wrap ? '0 : col + CW'(1);
   assign w_row_nxt = w_h_wrap ? (w_v_wrap ? '0 : row + CW'(1)) : row;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         HSync       <= ~H_POL;
         VSync       <= ~V_POL;
         active      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (ce) begin
         HSync       <= ((w_col_nxt >= HS_START) && (w_col_nxt < HS_END)) ? H_POL : ~H_POL;
         VSync       <= ((w_row_nxt >= VS_START) && (w_row_nxt < VS_END)) ? V_POL : ~V_POL;
         active      <= (w_col_nxt < H_ACT_END) && (w_row_nxt < V_ACT_END);
         line_start  <= (w_col_nxt == '0);
         frame_start <= (w_col_nxt == '0) && (w_row_nxt == '0);
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a reduced-geometry instance for whole frames.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   localparam int DHT = 800;
   localparam int DVT = 525;
   localparam int SHA = 20, SHF = 3, SHS = 5, SHB = 4;
   localparam int SVA = 12, SVF = 2, SVS = 2, SVB = 3;
   localparam int SHT = SHA + SHF + SHS + SHB;
   localparam int SVT = SVA + SVF + SVS + SVB;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   logic   ce = 1'b0;

   coord_t col_d, row_d, col_s, row_s;
   logic   hs_d, vs_d, act_d, ls_d, fs_d;
   logic   hs_s, vs_s, act_s, ls_s, fs_s;

   int     checks = 0;
   int     failures = 0;
   int     pos_d = -1;
   int     pos_s = -1;

   always #5 clk = ~clk;

   vga_timing_gen dut_d (
      .clk(clk), .rst_n(rst_n), .ce(ce),
      .col(col_d), .row(row_d), .HSync(hs_d), .VSync(vs_d),
      .active(act_d), .line_start(ls_d), .frame_start(fs_d)
   );

   vga_timing_gen #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
      .H_POL(1'b1), .V_POL(1'b0), .CW(10)
   ) dut_s (
      .clk(clk), .rst_n(rst_n), .ce(ce),
      .col(col_s), .row(row_s), .HSync(hs_s), .VSync(vs_s),
      .active(act_s), .line_start(ls_s), .frame_start(fs_s)
   );

   wire [25:0] obs_d = {col_d, row_d, hs_d, vs_d, act_d, ls_d, fs_d};
   wire [25:0] obs_s = {col_s, row_s, hs_s, vs_s, act_s, ls_s, fs_s};

   // Reference: pixel index within the frame (-1 = held in reset) mapped to the expected outputs.
   function automatic logic [25:0] model(input int pos, input int ha, input int hf, input int hsw,
                                         input int hb, input int va, input int vf, input int vsw,
                                         input int vb, input logic hp, input logic vp);
      int   ht, vt, c, r;
      logic h, v, a, ls, fs;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vb;
      if (pos < 0) begin
         c = ht - 1; r = vt - 1; h = ~hp; v = ~vp; a = 1'b0; ls = 1'b0; fs = 1'b0;
      end else begin
         c  = pos % ht;
         r  = pos / ht;
         h  = (c >= ha + hf && c < ha + hf + hsw) ? hp : ~hp;
         v  = (r >= va + vf && r < va + vf + vsw) ? vp : ~vp;
         a  = (c < ha) && (r < va);
         ls = (c == 0);
         fs = (c == 0) && (r == 0);
      end
      return {10'(c), 10'(r), h, v, a, ls, fs};
   endfunction

   function automatic logic [25:0] exp_d();
      return model(pos_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
   endfunction

   function automatic logic [25:0] exp_s();
      return model(pos_s, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1, 1'b0);
   endfunction

   // One clock: advance the reference on an enabled edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      if (rst_n && ce) begin
         pos_d = (pos_d + 1) % (DHT * DVT);
         pos_s = (pos_s + 1) % (SHT * SVT);
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ce = 1'(($urandom % 2));
         tick();
         checks++;
         if (obs_d !== exp_d()) begin
            failures++;
            $display("FAIL reset_default got=%h exp=%h", obs_d, exp_d());
         end
         checks++;
         if (obs_s !== exp_s()) begin
            failures++;
            $display("FAIL reset_small got=%h exp=%h", obs_s, exp_s());
         end
      end
   endtask

   task automatic test_first_pixel();
      rst_n = 1'b1;
      ce    = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (obs_d !== exp_d()) begin
            failures++;
            $display("FAIL first_pixel_default cyc=%0d got=%h exp=%h", i, obs_d, exp_d());
         end
         checks++;
         if (obs_s !== exp_s()) begin
            failures++;
            $display("FAIL first_pixel_small cyc=%0d got=%h exp=%h", i, obs_s, exp_s());
         end
      end
   endtask

   task automatic test_line_scan();
      int hs_low = 0, act_cnt = 0, ls_cnt = 0;
      ce = 1'b1;
      for (int i = 0; i < 2 * DHT; i++) begin
         tick();
         if (!hs_d) hs_low++;
         if (act_d) act_cnt++;
         if (ls_d) ls_cnt++;
         checks++;
         if (obs_d !== exp_d()) begin
            failures++;
            $display("FAIL line_scan pos=%0d got=%h exp=%h", pos_d, obs_d, exp_d());
         end
      end
      checks++;
      if (hs_low !== 192) begin
         failures++;
         $display("FAIL line_scan_hsync_width got=%0d exp=192", hs_low);
      end
      checks++;
      if (act_cnt !== 1280) begin
         failures++;
         $display("FAIL line_scan_active_count got=%0d exp=1280", act_cnt);
      end
      checks++;
      if (ls_cnt !== 2) begin
         failures++;
         $display("FAIL line_scan_line_starts got=%0d exp=2", ls_cnt);
      end
   endtask

   task automatic test_frame_wrap();
      int last = -1, pulses = 0, vs_low = 0;
      ce = 1'b1;
      for (int i = 0; i < 3 * SHT * SVT; i++) begin
         tick();
         if (!vs_s) vs_low++;
         checks++;
         if (obs_s !== exp_s()) begin
            failures++;
            $display("FAIL frame_wrap pos=%0d got=%h exp=%h", pos_s, obs_s, exp_s());
         end
         if (fs_s) begin
            pulses++;
            if (last >= 0) begin
               checks++;
               if (i - last !== SHT * SVT) begin
                  failures++;
                  $display("FAIL frame_period got=%0d exp=%0d", i - last, SHT * SVT);
               end
            end
            last = i;
         end
      end
      checks++;
      if (pulses !== 3) begin
         failures++;
         $display("FAIL frame_pulse_count got=%0d exp=3", pulses);
      end
      checks++;
      if (vs_low !== 3 * SVS * SHT) begin
         failures++;
         $display("FAIL frame_vsync_width got=%0d exp=%0d", vs_low, 3 * SVS * SHT);
      end
   endtask

   task automatic test_ce_toggle();
      int   last = -1, edges = 0;
      logic prev = fs_s;
      for (int i = 0; i < 2 * 2 * SHT * SVT + 4; i++) begin
         ce = ~ce;
         tick();
         checks++;
         if (obs_s !== exp_s()) begin
            failures++;
            $display("FAIL ce_toggle_small i=%0d got=%h exp=%h", i, obs_s, exp_s());
         end
         checks++;
         if (obs_d !== exp_d()) begin
            failures++;
            $display("FAIL ce_toggle_default i=%0d got=%h exp=%h", i, obs_d, exp_d());
         end
         if (fs_s && !prev) begin
            edges++;
            if (last >= 0) begin
               checks++;
               if (i - last !== 2 * SHT * SVT) begin
                  failures++;
                  $display("FAIL ce_toggle_period got=%0d exp=%0d", i - last, 2 * SHT * SVT);
               end
            end
            last = i;
         end
         prev = fs_s;
      end
      checks++;
      if (edges < 2) begin
         failures++;
         $display("FAIL ce_toggle_edges got=%0d exp>=2", edges);
      end
   endtask

   task automatic test_random_ce();
      for (int i = 0; i < 3000; i++) begin
         ce = 1'(($urandom % 4) != 0);
         tick();
         checks++;
         if (obs_s !== exp_s()) begin
            failures++;
            $display("FAIL random_ce_small i=%0d got=%h exp=%h", i, obs_s, exp_s());
         end
         checks++;
         if (obs_d !== exp_d()) begin
            failures++;
            $display("FAIL random_ce_default i=%0d got=%h exp=%h", i, obs_d, exp_d());
         end
      end
   endtask

   task automatic test_async_reset();
      int n = int'($urandom_range(50, 400));
      ce = 1'b1;
      for (int i = 0; i < n; i++) tick();
      #3;
      rst_n = 1'b0;
      pos_d = -1;
      pos_s = -1;
      #1;
      checks++;
      if (obs_d !== exp_d()) begin
         failures++;
         $display("FAIL async_reset_default got=%h exp=%h", obs_d, exp_d());
      end
      checks++;
      if (obs_s !== exp_s()) begin
         failures++;
         $display("FAIL async_reset_small got=%h exp=%h", obs_s, exp_s());
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs_s !== exp_s()) begin
            failures++;
            $display("FAIL reset_hold_small got=%h exp=%h", obs_s, exp_s());
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs_d !== exp_d()) begin
            failures++;
            $display("FAIL post_reset_default got=%h exp=%h", obs_d, exp_d());
         end
         checks++;
         if (obs_s !== exp_s()) begin
            failures++;
            $display("FAIL post_reset_small got=%h exp=%h", obs_s, exp_s());
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_pixel();
      test_line_scan();
      test_frame_wrap();
      test_ce_toggle();
      test_random_ce();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
